csa_accum_ctrl: RTL
===================

// Module: csa_accum_ctrl
// PURPOSE
//   Sequencer for the 64-bit 3:2 carry-save stage: streams N operands through the external CSA one per
//   accepted beat, holding redundant sum/carry state in registers. Then does a single carry-propagate
//   resolve and presents the binary total on a valid/ready output.
//   Sits between the operand producer (LCG term generator) and the downstream result consumer.
// PARAMETERS
//   WIDTH    64   datapath width; matches the CSA stage width
//   CNT_W    5    width of num_ops; max operands per job = 2**CNT_W-1
// PORTS
//   clk        in   1       single clock, rising edge
//   rst        in   1       asynchronous, active-high reset
//   start      in   1       job start pulse; sampled only in IDLE
//   num_ops    in   CNT_W   operand count for the job; latched on accepted start
//   in_valid   in   1       operand valid
//   in_ready   out  1       operand ready; high only in ACCUM
//   in_data    in   WIDTH   operand
//   csa_a      out  WIDTH   CSA input a = sum register S
//   csa_b      out  WIDTH   CSA input b = carry register C (already weighted, bit0=0)
//   csa_c      out  WIDTH   CSA input c = in_data
//   csa_sum    in   WIDTH   CSA sum output
//   csa_cy     in   WIDTH   CSA carry output (unshifted)
//   out_valid  out  1       result valid; high only in DONE
//   out_ready  in   1       consumer ready
//   result     out  WIDTH   S+C mod 2**WIDTH
//   busy       out  1       state != IDLE
//   ovf        out  1       overflow flag (see CONFIGURATION)
// BEHAVIOUR
//   Reset (async, rst=1): state=IDLE, S=0, C=0, cnt=0, result=0, ovf=0, in_ready=0, out_valid=0, busy=0.
//   FSM IDLE->ACCUM->RESOLVE->DONE->IDLE.
//   IDLE: on start, S<=0, C<=0, ovf<=0, cnt<=num_ops. Next state is ACCUM if num_ops!=0; else RESOLVE.
//   ACCUM: in_ready=1. A beat is accepted when in_valid&in_ready.
//     - Each accept: S<=csa_sum, C<={csa_cy[WIDTH-2:0],1'b0}, cnt<=cnt-1.
//     - The accept with cnt==1 moves to RESOLVE. No accept means state held, S/C unchanged.
//   RESOLVE: one cycle. result<=S+C truncated to WIDTH; ->DONE.
//   DONE: out_valid=1, result stable until out_valid&out_ready; then ->IDLE same edge.
//   Latency, continuous in_valid: out_valid rises N+2 cycles after the start edge (N accepts, RESOLVE, DONE).
//   csa_a/b/c are combinational from S, C and in_data, and are valid in every state.
//   CSA outputs are used only on accepted beats.
//   start outside IDLE is ignored; num_ops is not re-latched.
//   in_valid outside ACCUM is ignored (in_ready=0).
//   Wrap-around: all arithmetic is mod 2**WIDTH. csa_cy[WIDTH-1] and the final-add carry-out are discarded.
//   Reset mid-job: immediate return to IDLE and reset values. The partial job is lost and no out_valid is produced.
//   num_ops=0: job yields result=0 with out_valid two cycles after start.
// CONFIGURATION
//   CSA_ACC_OVF_EN defined:
//     - ovf is set, sticky per job, when any accepted beat has csa_cy[WIDTH-1]=1 or the RESOLVE add carries out of bit WIDTH-1.
//     - ovf is cleared on accepted start and valid alongside result.
//   CSA_ACC_OVF_EN undefined: ovf is tied 0 and no tracking logic is present.
// TESTING
//   T1 num_ops=3, in_data 1,2,3 back-to-back -> result=6, out_valid 5 cycles after start, ovf=0.
//   T2 num_ops=4, in_valid gaps of 2 cycles, out_ready low 3 cycles in DONE -> result=sum, result held while out_ready low.
//   T3 num_ops=2, in_data 64'hFFFF_FFFF_FFFF_FFFF and 1 -> result=0; ovf=1 with CSA_ACC_OVF_EN, 0 without.
//   T4 num_ops=0 -> in_ready never high, result=0, out_valid 2 cycles after start.
//   T5 start pulsed in ACCUM and DONE -> ignored; result is from the first job only.
//   T6 rst asserted after 2 of 5 operands -> all outputs reset immediately; new job num_ops=1, data=7 -> result=7.

Source files
------------

// File: rtl/csa_accum_ctrl.sv
// Sequencer for an external 64-bit 3:2 carry-save stage: accumulates N operands redundantly, then
// resolves S+C once and hands the total out on valid/ready. Optional overflow flag: CSA_ACC_OVF_EN.
module csa_accum_ctrl #(
   parameter int unsigned WIDTH = 64,
   parameter int unsigned CNT_W = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [CNT_W-1:0] num_ops,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic [WIDTH-1:0] csa_a,
   output logic [WIDTH-1:0] csa_b,
   output logic [WIDTH-1:0] csa_c,
   input  logic [WIDTH-1:0] csa_sum,
   input  logic [WIDTH-1:0] csa_cy,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             busy,
   output logic             ovf
);

   typedef enum logic [1:0] {StIdle, StAccum, StResolve, StDone} state_e;

   state_e             state_q, state_d;
   logic [WIDTH-1:0]   s_q, s_d;
   logic [WIDTH-1:0]   c_q, c_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [WIDTH-1:0]   result_q, result_d;
   logic               accept;

   assign in_ready  = (state_q == StAccum);
   assign out_valid = (state_q == StDone);
   assign busy      = (state_q != StIdle);
   assign accept    = in_valid & in_ready;
   assign result    = result_q;

   assign csa_a = s_q;
   assign csa_b = c_q;
   assign csa_c = in_data;

`ifdef CSA_ACC_OVF_EN
   logic             ovf_q, ovf_d;
   logic [WIDTH:0]   resolve_sum;

   assign resolve_sum = {1'b0, s_q} + {1'b0, c_q};
   assign ovf         = ovf_q;

   always_comb begin
      ovf_d = ovf_q;
      if (state_q == StIdle && start) begin
         ovf_d = 1'b0;
      end else if (accept) begin
         ovf_d = ovf_q | csa_cy[WIDTH-1];
      end else if (state_q == StResolve) begin
         ovf_d = ovf_q | resolve_sum[WIDTH];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ovf_q <= 1'b0;
      end else begin
         ovf_q <= ovf_d;
      end
   end
`else
   logic [WIDTH-1:0] resolve_sum;
   logic             unused_cy_msb;

   // The carry shifted out of the top is simply dropped when overflow is not tracked.
   assign unused_cy_msb = csa_cy[WIDTH-1];
   assign resolve_sum   = s_q + c_q;
   assign ovf           = 1'b0;
`endif

   always_comb begin
      state_d  = state_q;
      s_d      = s_q;
      c_d      = c_q;
      cnt_d    = cnt_q;
      result_d = result_q;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               s_d     = '0;
               c_d     = '0;
               cnt_d   = num_ops;
               state_d = (num_ops != '0) ? StAccum : StResolve;
            end
         end
         StAccum: begin
            if (accept) begin
               s_d   = csa_sum;
               // Carry is stored pre-weighted so it can feed the next CSA beat directly.
               c_d   = {csa_cy[WIDTH-2:0], 1'b0};
               cnt_d = cnt_q - CNT_W'(1);
               if (cnt_q == CNT_W'(1)) begin
                  state_d = StResolve;
               end
            end
         end
         StResolve: begin
            result_d = resolve_sum[WIDTH-1:0];
            state_d  = StDone;
         end
         StDone: begin
            if (out_ready) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= StIdle;
         s_q      <= '0;
         c_q      <= '0;
         cnt_q    <= '0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         s_q      <= s_d;
         c_q      <= c_d;
         cnt_q    <= cnt_d;
         result_q <= result_d;
      end
   end

endmodule
